// File: rtl/alu_io_pkg.sv
// Shared widths and loader state encoding for the 6-bit ALU input stage.
package alu_io_pkg;

    localparam int DATA_W = 6;
    localparam int MODE_W = 3;

    // Values double as the LED 'stage' encoding.
    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_MODE  = 2'd2,
        S_READY = 2'd3
    } stage_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// 'press' pulses for one cycle on each accepted rising edge of 'level'.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable gets a default before any branch, so no latch
    // can be inferred.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // The D-th consecutive differing cycle flips the level; the
            // counter therefore never reaches DEBOUNCE_CYCLES and cannot wrap.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and mode from the switches over three debounced presses
// and presents them to the ALU with a one-cycle op_valid strobe.
module alu_operand_loader
    import alu_io_pkg::*;
#(
    parameter int DATA_W          = alu_io_pkg::DATA_W,
    parameter int MODE_W          = alu_io_pkg::MODE_W,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic [MODE_W-1:0] mode_sw,
    input  logic              btn_load,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [MODE_W-1:0] mode,
    output logic              op_valid,
    output logic              ready,
    output logic [1:0]        stage
);

    logic load_level, load_press;
    logic clr_level, clr_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_load),
        .level   (load_level),
        .press   (load_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clr),
        .level   (clr_level),
        .press   (clr_press)
    );

    stage_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        valid_d = 1'b0;
        // Clear outranks a coincident load press, which is simply dropped.
        if (clr_press) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            mode_d  = '0;
        end else if (load_press) begin
            unique case (state_q)
                S_A, S_READY: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_MODE;
                end
                S_MODE: begin
                    mode_d  = mode_sw;
                    valid_d = 1'b1;
                    state_d = S_READY;
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign mode     = mode_q;
    assign op_valid = valid_q;
    assign ready    = (state_q == S_READY);
    assign stage    = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench: directed scenarios plus random button traffic
// compared against a sample-window model of debounce and capture.
module tb_alu_operand_loader;

    localparam int DW = 6;
    localparam int MW = 3;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sw = '0;
    logic [MW-1:0] mode_sw = '0;
    logic          btn_load = 1'b0;
    logic          btn_clr = 1'b0;
    logic [DW-1:0] A, B;
    logic [MW-1:0] mode;
    logic          op_valid, ready;
    logic [1:0]    stage;

    alu_operand_loader #(
        .DATA_W          (DW),
        .MODE_W          (MW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .mode_sw  (mode_sw),
        .btn_load (btn_load),
        .btn_clr  (btn_clr),
        .A        (A),
        .B        (B),
        .mode     (mode),
        .op_valid (op_valid),
        .ready    (ready),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;
    int valid_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: raw samples per edge are kept in a shift history;
    // the synced view lags raw by two edges, and a level flips once the last
    // DB synced samples all disagree with it. Captures follow one edge later.
    logic [DB+1:0] hist_l, hist_c;
    bit            m_lvl_l, m_lvl_c, m_pl, m_pc, m_valid;
    logic [1:0]    m_stage;
    logic [DW-1:0] m_a, m_b;
    logic [MW-1:0] m_mode;

    task automatic model_reset();
        hist_l = '0; hist_c = '0;
        m_lvl_l = 0; m_lvl_c = 0; m_pl = 0; m_pc = 0; m_valid = 0;
        m_stage = 2'd0; m_a = '0; m_b = '0; m_mode = '0;
    endtask

    task automatic model_edge();
        m_valid = 0;
        if (m_pc) begin
            m_a = '0; m_b = '0; m_mode = '0; m_stage = 2'd0;
        end else if (m_pl) begin
            case (m_stage)
                2'd0, 2'd3: begin m_a = sw; m_stage = 2'd1; end
                2'd1:       begin m_b = sw; m_stage = 2'd2; end
                default:    begin m_mode = mode_sw; m_stage = 2'd3; m_valid = 1; end
            endcase
        end
        hist_l = {hist_l[DB:0], btn_load};
        hist_c = {hist_c[DB:0], btn_clr};
        m_pl = 0;
        m_pc = 0;
        if (hist_l[DB+1:2] == {DB{~m_lvl_l}}) begin
            m_lvl_l = ~m_lvl_l;
            m_pl    = m_lvl_l;
        end
        if (hist_c[DB+1:2] == {DB{~m_lvl_c}}) begin
            m_lvl_c = ~m_lvl_c;
            m_pc    = m_lvl_c;
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (op_valid === 1'b1) valid_seen++;
        check("outputs", 32'({A, B, mode, op_valid, ready, stage}),
              32'({m_a, m_b, m_mode, m_valid, (m_stage == 2'd3), m_stage}));
    endtask

    task automatic press_load(input logic [DW-1:0] s, input logic [MW-1:0] m);
        sw = s; mode_sw = m; btn_load = 1'b1;
        repeat (DB + 3) step();
        btn_load = 1'b0;
        repeat (DB + 3) step();
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        repeat (DB + 3) step();
        btn_clr = 1'b0;
        repeat (DB + 3) step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({A, B, mode, op_valid, ready, stage}), 32'd0);
        rst_n = 1'b1;

        // Clean press: capture lands on the 7th edge after the button rises.
        sw = 6'b000111;
        btn_load = 1'b1;
        repeat (DB + 2) step();
        check("clean_stage_before", 32'(stage), 32'd0);
        step();
        check("clean_A", 32'(A), 32'h07);
        check("clean_stage", 32'(stage), 32'd1);
        btn_load = 1'b0;
        repeat (DB + 3) step();
        press_clr();
        check("clr_stage", 32'(stage), 32'd0);

        // Asynchronous reset in the middle of a set.
        press_load(6'b010101, 3'd0);
        check("pre_reset_A", 32'(A), 32'h15);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({A, B, mode, op_valid, ready, stage}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Bouncing button: 2-cycle pulses never survive the filter.
        press_load(6'b101010, 3'd0);
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            repeat (2) step();
        end
        btn_load = 1'b0;
        repeat (DB + 4) step();
        check("bounce_A", 32'(A), 32'h2A);
        check("bounce_stage", 32'(stage), 32'd1);

        // Full set of three captures.
        press_clr();
        valid_seen = 0;
        press_load(6'b011010, 3'd0);
        press_load(6'b000110, 3'd0);
        press_load(6'b111111, 3'b011);
        check("full_A", 32'(A), 32'h1A);
        check("full_B", 32'(B), 32'h06);
        check("full_mode", 32'(mode), 32'd3);
        check("full_ready", 32'(ready), 32'd1);
        check("full_valid_pulses", 32'(valid_seen), 32'd1);

        // Restart from S_READY.
        valid_seen = 0;
        press_load(6'b110011, 3'd5);
        check("restart_A", 32'(A), 32'h33);
        check("restart_B", 32'(B), 32'h06);
        check("restart_ready", 32'(ready), 32'd0);
        check("restart_stage", 32'(stage), 32'd1);
        check("restart_valid", 32'(valid_seen), 32'd0);

        // Clear and load together while in S_MODE.
        press_load(6'b001100, 3'd0);
        check("pre_simul_stage", 32'(stage), 32'd2);
        valid_seen = 0;
        mode_sw = 3'd6;
        btn_load = 1'b1; btn_clr = 1'b1;
        repeat (DB + 3) step();
        btn_load = 1'b0; btn_clr = 1'b0;
        repeat (DB + 3) step();
        check("simul_regs", 32'({A, B, mode}), 32'd0);
        check("simul_stage", 32'(stage), 32'd0);
        check("simul_valid", 32'(valid_seen), 32'd0);

        // Random button traffic with mixed short (bounce) and long holds.
        for (int seg = 0; seg < 300; seg++) begin
            btn_load = 1'($urandom_range(0, 1));
            btn_clr  = ($urandom_range(0, 5) == 0);
            sw       = DW'($urandom);
            mode_sw  = MW'($urandom);
            repeat ($urandom_range(1, 9)) step();
        end
        btn_load = 1'b0; btn_clr = 1'b0;
        repeat (DB + 4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Upstream input stage for the 6-bit ALU on the Basys3 board. It takes raw slide-switch values and two raw push-buttons, and debounces the buttons. A small state machine then captures operand A, operand B and the 3-bit mode in three successive presses. It drives the ALU's `A`, `B` and `mode` inputs directly and issues a one-cycle `op_valid` strobe once a complete operand set is held stable.

## Interface

- `DATA_W`, 6, operand width; matches ALU `A`/`B`.
- `MODE_W`, 3, ALU mode width.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.

Ports:

- `clk`  in  1  system clock (100 MHz on board).
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  DATA_W  raw operand switches; asynchronous to `clk`, quasi-static.
- `mode_sw`  in  MODE_W  raw mode switches.
- `btn_load`  in  1  raw "next" button; asynchronous, bouncing.
- `btn_clr`  in  1  raw clear button; asynchronous, bouncing.
- `A`  out  DATA_W  captured operand A.
- `B`  out  DATA_W  captured operand B.
- `mode`  out  MODE_W  captured ALU mode.
- `op_valid`  out  1  one-cycle strobe: A/B/mode form a complete new set.
- `ready`  out  1  high while in S_READY.
- `stage`  out  2  current state encoding, for LEDs.

## Operation

- Each button passes through its own `btn_debounce` instance, giving a one-cycle `press` pulse on each accepted rising edge of the debounced level. Release produces no pulse.
- `sw` and `mode_sw` are sampled only at capture. They are not synchronised, and the user must hold them static during the press.
- States (`stage` encoding): S_A=0, S_B=1, S_MODE=2, S_READY=3.
- S_A + load press: `A`<=`sw`, go to S_B.
- S_B + load press: `B`<=`sw`, go to S_MODE.
- S_MODE + load press: `mode`<=`mode_sw`, go to S_READY, and `op_valid`=1 for the following cycle.
- S_READY + load press: `A`<=`sw`, go to S_B. This starts a new set, so `ready` drops.
- Clear press in any state: `A`, `B` and `mode` go to 0 and the state goes to S_A. No `op_valid`.
- Clear press and load press on the same cycle: clear wins and the load press is discarded.
- `A`, `B` and `mode` change only on their own capture or on clear. Between captures they hold, so the ALU sees partially updated sets only while `ready`=0.

## Timing

- Reset (async assert, sync deassert by board convention):
  - `A`=0, `B`=0, `mode`=0, `op_valid`=0, `ready`=0, `stage`=0.
  - Synchroniser flops, debounced levels and counters all 0.
- Synchroniser: 2 flops per button.
- Debounce counting:
  - The counter increments each cycle the synced level differs from the debounced level.
  - It resets to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press latency: with the raw button high from before edge 1, the debounced level and `press` are both registered at edge DEBOUNCE_CYCLES+2. `press` is high for exactly one cycle.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no pulse.
- Capture: the output register updates on the edge following `press` high, i.e. 1 cycle after `press`.
- `op_valid` rises on the same edge that updates `mode` and falls one cycle later. `ready` rises on that same edge.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter must not wrap, because it saturates by construction at the flip.

## Structure

- Package `alu_io_pkg`:
  - State encodings S_A..S_READY as a 2-bit typedef.
  - Default widths DATA_W=6 and MODE_W=3, shared with the ALU and top level.
- Sub-module `btn_debounce`:
  - Parameter DEBOUNCE_CYCLES.
  - Ports `clk`, `rst_n`, `btn_raw`, `level`, `press`.
  - Instantiated twice.
- The FSM and capture registers live in `alu_operand_loader`.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset mid-sequence: after capturing A=6'b010101, assert `rst_n`=0 asynchronously → all outputs 0 immediately, `stage`=0.
- Clean press: `btn_load` held high from cycle 0 → `press` high only in cycle 6. `A` takes `sw`=6'b000111 at cycle 7, and `stage`=1.
- Bounce: `btn_load` toggles high/low every 2 cycles for 20 cycles, then goes low → no `press`, and `A` is unchanged.
- Full set: three clean presses with `sw`=6'b011010, then 6'b000110, then `mode_sw`=3'b011 → `A`=6'b011010, `B`=6'b000110, `mode`=3'b011. `op_valid` is a single cycle and `ready`=1.
- Restart from S_READY: a press with `sw`=6'b110011 → `A`=6'b110011, `B` still 6'b000110, `ready`=0, `stage`=1, no `op_valid`.
- Simultaneous clear and load: both buttons pressed on the same cycle in S_MODE → `A`=`B`=`mode`=0, `stage`=0, and no `op_valid`.
